// File: rtl/wave_crossfade_if.sv
// Generator-side bus of the crossfade engine: two wave generator slots
// sharing one index, each with its own frequency, load strobe, height and ready.
interface wave_crossfade_if #(
    parameter int W_X = 11,
    parameter int W_H = 10,
    parameter int W_F = 5
);
    logic [W_X-1:0]   gen_index;
    logic [2*W_F-1:0] gen_freq_id;
    logic [1:0]       gen_new_f;
    logic [2*W_H-1:0] gen_height;
    logic [1:0]       gen_ready;

    modport master (
        output gen_index, gen_freq_id, gen_new_f,
        input  gen_height, gen_ready
    );

    modport slave (
        input  gen_index, gen_freq_id, gen_new_f,
        output gen_height, gen_ready
    );
endinterface

// File: rtl/wave_crossfade.sv
// Ping-pong crossfade engine: loads new frequencies into the idle generator slot,
// swaps on ready, and blends previous/current heights with a per-frame decaying weight.
module wave_crossfade #(
    parameter int W_X         = 11,
    parameter int W_H         = 10,
    parameter int W_F         = 5,
    parameter int W_C         = 8,
    parameter int MODE        = 0,
    parameter int DECAY_SHIFT = 1,
    parameter int LIN_STEP    = 16,
    parameter int GEN_LAT     = 1,
    parameter int TIMEOUT     = 4095
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             vsync_i,
    input  logic [W_X-1:0]   hcount_i,
    input  logic [W_X-1:0]   offset_i,
    input  logic [W_F-1:0]   freq_id_i,
    input  logic             new_f_i,
    wave_crossfade_if.master gen_if,
    output logic [W_H-1:0]   wave_profile_o,
    output logic [W_H-1:0]   player_profile_o,
    output logic             busy_o,
    output logic             err_o
);
    localparam int              PW        = W_H + W_C + 1;
    localparam int              TW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W_C-1:0]  COEFF_MAX = {W_C{1'b1}};
    localparam logic [W_C:0]    COEFF_ONE = {1'b1, {W_C{1'b0}}};
    localparam logic [TW-1:0]   TIMER_END = TW'(TIMEOUT);

    // The generator latency is absorbed externally; only sanity-check it here.
    if (GEN_LAT < 0 || TIMEOUT < 1) begin : g_bad_params
        $error("wave_crossfade: GEN_LAT must be >= 0 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT, S_SWAP} state_e;

    state_e              state_q, state_d;
    logic                cur_q, cur_d;
    logic [W_C-1:0]      coeff_q, coeff_d;
    logic                pend_valid_q, pend_valid_d;
    logic [W_F-1:0]      pend_id_q, pend_id_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                err_q, err_d;
    logic                vsync_q;
    logic [1:0][W_F-1:0] slot_id_q, slot_id_d;

    logic                vsync_rise;
    logic [W_C-1:0]      decay_step;
    logic [W_C-1:0]      coeff_decayed;

    assign vsync_rise = vsync_i & ~vsync_q;

    always_comb begin
        decay_step = coeff_q >> DECAY_SHIFT;
        if (decay_step == '0) decay_step = W_C'(1);
        if (MODE == 0)                       coeff_decayed = coeff_q - decay_step;
        else if (int'(coeff_q) > LIN_STEP)   coeff_decayed = coeff_q - W_C'(LIN_STEP);
        else                                 coeff_decayed = '0;
    end

    // NOTE: every signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        coeff_d      = coeff_q;
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        timer_d      = timer_q;
        err_d        = err_q;
        slot_id_d    = slot_id_q;

        if (vsync_rise && coeff_q != '0) coeff_d = coeff_decayed;

        if (new_f_i && state_q != S_IDLE) begin
            pend_id_d    = freq_id_i;
            pend_valid_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (new_f_i || pend_valid_q) begin
                    slot_id_d[~cur_q] = new_f_i ? freq_id_i : pend_id_q;
                    pend_valid_d      = 1'b0;
                    state_d           = S_LOAD;
                end
            end
            S_LOAD: begin
                timer_d = '0;
                state_d = S_ARM;
            end
            S_ARM: state_d = S_WAIT;
            S_WAIT: begin
                if (gen_if.gen_ready[~cur_q]) begin
                    state_d = S_SWAP;
                end else if (timer_q == TIMER_END) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_SWAP: begin
                // A swap overrides any decay landing in the same cycle.
                cur_d   = ~cur_q;
                coeff_d = COEFF_MAX;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cur_q        <= 1'b0;
            coeff_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            timer_q      <= '0;
            err_q        <= 1'b0;
            vsync_q      <= 1'b0;
            slot_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            coeff_q      <= coeff_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            vsync_q      <= vsync_i;
            slot_id_q    <= slot_id_d;
        end
    end

    logic [W_X-1:0] gen_index_q;
    logic [W_H-1:0] h_slot0, h_slot1, h_cur, h_prev;
    logic [W_C:0]   cur_weight;
    logic [PW-1:0]  prod_cur_q, prod_prev_q, blend_sum;
    logic [W_H-1:0] wave_mid_q, wave_q, player_q;

    assign h_slot0    = gen_if.gen_height[W_H-1:0];
    assign h_slot1    = gen_if.gen_height[2*W_H-1:W_H];
    assign h_cur      = cur_q ? h_slot1 : h_slot0;
    assign h_prev     = cur_q ? h_slot0 : h_slot1;
    assign cur_weight = COEFF_ONE - {1'b0, coeff_q};
    assign blend_sum  = prod_cur_q + prod_prev_q;

    // NOTE: the datapath registers are reset too, because the profiles must read zero out of reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            gen_index_q <= '0;
            prod_cur_q  <= '0;
            prod_prev_q <= '0;
            wave_mid_q  <= '0;
            wave_q      <= '0;
            player_q    <= '0;
        end else begin
            gen_index_q <= hcount_i + offset_i;
            // Slot select and weight are sampled here so a swap lands on a sample boundary.
            prod_cur_q  <= PW'(h_cur) * PW'(cur_weight);
            prod_prev_q <= PW'(h_prev) * PW'(coeff_q);
            wave_mid_q  <= h_cur;
            wave_q      <= wave_mid_q;
            player_q    <= W_H'(blend_sum >> W_C);
        end
    end

    assign gen_if.gen_index   = gen_index_q;
    assign gen_if.gen_freq_id = slot_id_q;
    assign gen_if.gen_new_f   = (state_q == S_LOAD) ? (cur_q ? 2'b01 : 2'b10) : 2'b00;

    assign wave_profile_o   = wave_q;
    assign player_profile_o = player_q;
    assign busy_o           = (state_q != S_IDLE);
    assign err_o            = err_q;
endmodule

// File: tb/tb_wave_crossfade.sv
// Directed bench for wave_crossfade: exponential (dut_a) and linear (dut_b) decay
// instances share the front end; each has its own behavioural generator pair.
`timescale 1ns/1ps
module tb_wave_crossfade;
    localparam int W_X = 11;
    localparam int W_H = 10;
    localparam int W_F = 5;

    logic           clk = 1'b0;
    logic           rst, vsync, new_f;
    logic [W_X-1:0] hcount, offset;
    logic [W_F-1:0] freq_id;
    logic [W_H-1:0] wave_a, player_a, wave_b, player_b;
    logic           busy_a, err_a, busy_b, err_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wave_crossfade_if #(.W_X(W_X), .W_H(W_H), .W_F(W_F)) if_a ();
    wave_crossfade_if #(.W_X(W_X), .W_H(W_H), .W_F(W_F)) if_b ();

    wave_crossfade #(.MODE(0)) dut_a (
        .clock_i(clk), .reset_i(rst), .vsync_i(vsync), .hcount_i(hcount), .offset_i(offset),
        .freq_id_i(freq_id), .new_f_i(new_f), .gen_if(if_a),
        .wave_profile_o(wave_a), .player_profile_o(player_a), .busy_o(busy_a), .err_o(err_a)
    );

    wave_crossfade #(.MODE(1), .LIN_STEP(16)) dut_b (
        .clock_i(clk), .reset_i(rst), .vsync_i(vsync), .hcount_i(hcount), .offset_i(offset),
        .freq_id_i(freq_id), .new_f_i(new_f), .gen_if(if_b),
        .wave_profile_o(wave_b), .player_profile_o(player_b), .busy_o(busy_b), .err_o(err_b)
    );

    // Generator model: ready drops on a load strobe and rises rdy_dly cycles later.
    logic           ready_en = 1'b1;
    int             rdy_dly = 3;
    logic           h_from_index = 1'b0;
    logic [W_H-1:0] h_const [2] = '{256, 0};
    logic [1:0]     rdy_a = 2'b00, rdy_b = 2'b00;
    int             cnt_a [2] = '{0, 0};
    int             cnt_b [2] = '{0, 0};
    logic [W_H-1:0] ha [2] = '{0, 0};
    logic [W_H-1:0] hb [2] = '{0, 0};
    int             log_q [$];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (if_a.gen_new_f[k]) begin
                rdy_a[k] <= 1'b0; cnt_a[k] <= rdy_dly - 1;
                log_q.push_back(k * 100 + int'(if_a.gen_freq_id[k*W_F +: W_F]));
            end else if (cnt_a[k] > 0) begin
                cnt_a[k] <= cnt_a[k] - 1;
                if (cnt_a[k] == 1 && ready_en) rdy_a[k] <= 1'b1;
            end
            if (if_b.gen_new_f[k]) begin
                rdy_b[k] <= 1'b0; cnt_b[k] <= rdy_dly - 1;
            end else if (cnt_b[k] > 0) begin
                cnt_b[k] <= cnt_b[k] - 1;
                if (cnt_b[k] == 1 && ready_en) rdy_b[k] <= 1'b1;
            end
            ha[k] <= h_from_index ? if_a.gen_index[W_H-1:0] : h_const[k];
            hb[k] <= h_from_index ? if_b.gen_index[W_H-1:0] : h_const[k];
        end
    end

    assign if_a.gen_height = {ha[1], ha[0]};
    assign if_a.gen_ready  = rdy_a;
    assign if_b.gen_height = {hb[1], hb[0]};
    assign if_b.gen_ready  = rdy_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1; repeat (3) tick();
        vsync = 1'b0; repeat (4) tick();
    endtask

    task automatic request(input logic [W_F-1:0] id);
        freq_id = id; new_f = 1'b1; tick(); new_f = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy_a && n < limit) begin tick(); n++; end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL %s_idle_bound still busy after %0d cycles", name, n); end
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b0; new_f = 1'b0; hcount = '0; offset = '0; freq_id = '0;
        repeat (3) tick();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_a); end
        checks++; if (if_a.gen_new_f !== 2'b00) begin failures++; $display("FAIL reset_new_f got=%b exp=00", if_a.gen_new_f); end
        checks++; if (if_a.gen_freq_id !== 10'd0) begin failures++; $display("FAIL reset_freq_id got=%0d exp=0", if_a.gen_freq_id); end
        checks++; if (if_a.gen_index !== 11'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", if_a.gen_index); end
        checks++; if (wave_a !== 10'd0) begin failures++; $display("FAIL reset_wave got=%0d exp=0", wave_a); end
        checks++; if (player_a !== 10'd0) begin failures++; $display("FAIL reset_player got=%0d exp=0", player_a); end
        rst = 1'b0;
        repeat (4) tick();
        // cur=0, coeff=0: both profiles follow slot0.
        checks++; if (wave_a !== 10'd256) begin failures++; $display("FAIL reset_cur_wave got=%0d exp=256", wave_a); end
        checks++; if (player_a !== 10'd256) begin failures++; $display("FAIL reset_cur_player got=%0d exp=256", player_a); end
    endtask

    task automatic test_load_swap();
        int n;
        request(5'd7);
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL load_busy got=%0b exp=1", busy_a); end
        checks++; if (if_a.gen_new_f !== 2'b10) begin failures++; $display("FAIL load_strobe got=%b exp=10", if_a.gen_new_f); end
        checks++; if (if_a.gen_freq_id !== 10'd224) begin failures++; $display("FAIL load_freq_id got=%0d exp=224", if_a.gen_freq_id); end
        tick();
        checks++; if (if_a.gen_new_f !== 2'b00) begin failures++; $display("FAIL arm_strobe got=%b exp=00", if_a.gen_new_f); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL arm_busy got=%0b exp=1", busy_a); end
        n = 2;
        while (busy_a && n < 30) begin tick(); n++; end
        // LOAD, ARM, WAIT, WAIT(ready), SWAP: idle from the 6th cycle.
        checks++; if (n !== 6) begin failures++; $display("FAIL busy_span got=%0d exp=6", n); end
        repeat (3) tick();
        checks++; if (wave_a !== 10'd0) begin failures++; $display("FAIL swap_cur_wave got=%0d exp=0", wave_a); end
        checks++; if (player_a !== 10'd255) begin failures++; $display("FAIL swap_coeff_a got=%0d exp=255", player_a); end
        checks++; if (player_b !== 10'd255) begin failures++; $display("FAIL swap_coeff_b got=%0d exp=255", player_b); end
    endtask

    task automatic test_decay();
        int exp_tab [9] = '{128, 64, 32, 16, 8, 4, 2, 1, 0};
        int ea, eb;
        for (int i = 0; i < 17; i++) begin
            pulse_vsync();
            ea = (i < 9) ? exp_tab[i] : 0;
            eb = (255 - 16 * (i + 1) > 0) ? 255 - 16 * (i + 1) : 0;
            checks++; if (int'(player_a) !== ea) begin failures++; $display("FAIL decay_exp[%0d] got=%0d exp=%0d", i, player_a, ea); end
            checks++; if (int'(player_b) !== eb) begin failures++; $display("FAIL decay_lin[%0d] got=%0d exp=%0d", i, player_b, eb); end
        end
    endtask

    task automatic test_blend();
        h_const = '{400, 100};
        repeat (4) tick();
        // cur=1 (height 100), coeff=0 on both instances.
        checks++; if (wave_a !== 10'd100) begin failures++; $display("FAIL blend_c0_wave got=%0d exp=100", wave_a); end
        checks++; if (player_a !== 10'd100) begin failures++; $display("FAIL blend_c0_player got=%0d exp=100", player_a); end
        request(5'd5);
        wait_idle("blend", 30);
        checks++; if (if_a.gen_freq_id !== 10'd229) begin failures++; $display("FAIL blend_freq_id got=%0d exp=229", if_a.gen_freq_id); end
        repeat (3) tick();
        checks++; if (wave_a !== 10'd400) begin failures++; $display("FAIL blend_c255_wave got=%0d exp=400", wave_a); end
        checks++; if (player_a !== 10'd101) begin failures++; $display("FAIL blend_c255_player got=%0d exp=101", player_a); end
        pulse_vsync();
        checks++; if (player_a !== 10'd250) begin failures++; $display("FAIL blend_c128_player got=%0d exp=250", player_a); end
        checks++; if (wave_a !== 10'd400) begin failures++; $display("FAIL blend_c128_wave got=%0d exp=400", wave_a); end
        checks++; if (player_b !== 10'd119) begin failures++; $display("FAIL blend_c239_player got=%0d exp=119", player_b); end
    endtask

    task automatic test_latency();
        int hc  [7] = '{0, 5, 1000, 1023, 2000, 2047, 600};
        int off [7] = '{0, 10, 23, 1, 100, 2047, 700};
        int idx [7] = '{0, 15, 1023, 1024, 52, 2046, 1300};
        int prf [7] = '{0, 15, 1023, 0, 52, 1022, 276};
        h_from_index = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j < 7) begin hcount = W_X'(hc[j]); offset = W_X'(off[j]); end
            tick();
            if (j < 7) begin
                checks++; if (int'(if_a.gen_index) !== idx[j]) begin failures++; $display("FAIL index[%0d] got=%0d exp=%0d", j, if_a.gen_index, idx[j]); end
            end
            if (j >= 3) begin
                checks++; if (int'(wave_a) !== prf[j-3]) begin failures++; $display("FAIL lat_wave[%0d] got=%0d exp=%0d", j - 3, wave_a, prf[j-3]); end
                checks++; if (int'(player_a) !== prf[j-3]) begin failures++; $display("FAIL lat_player[%0d] got=%0d exp=%0d", j - 3, player_a, prf[j-3]); end
            end
        end
        h_from_index = 1'b0;
        hcount = 11'd100; offset = 11'd5;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        log_q.delete();
        rdy_dly = 8;
        request(5'd3);
        tick(); tick();
        request(5'd9);
        request(5'd12);
        while ((busy_a || log_q.size() < 2) && n < 100) begin tick(); n++; end
        repeat (4) tick();
        checks++; if (log_q.size() !== 2) begin
            failures++; $display("FAIL queue_count got=%0d exp=2", log_q.size());
        end else begin
            checks++; if (log_q[0] !== 103) begin failures++; $display("FAIL queue_first got=%0d exp=103", log_q[0]); end
            checks++; if (log_q[1] !== 12) begin failures++; $display("FAIL queue_second got=%0d exp=12", log_q[1]); end
        end
        checks++; if (wave_a !== 10'd400) begin failures++; $display("FAIL queue_cur_wave got=%0d exp=400", wave_a); end
        rdy_dly = 3;
    endtask

    task automatic test_timeout();
        int n;
        ready_en = 1'b0;
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL timeout_err_before got=%0b exp=0", err_a); end
        request(5'd4);
        n = 1;
        while (busy_a && n < 5000) begin tick(); n++; end
        // LOAD + ARM + 4096 WAIT cycles.
        checks++; if (n !== 4099) begin failures++; $display("FAIL timeout_span got=%0d exp=4099", n); end
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL timeout_err got=%0b exp=1", err_a); end
        repeat (3) tick();
        checks++; if (wave_a !== 10'd400) begin failures++; $display("FAIL timeout_cur_wave got=%0d exp=400", wave_a); end
        ready_en = 1'b1;
        request(5'd6);
        wait_idle("after_timeout", 30);
        repeat (3) tick();
        checks++; if (wave_a !== 10'd100) begin failures++; $display("FAIL after_timeout_wave got=%0d exp=100", wave_a); end
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err_a); end
        checks++; if (if_a.gen_freq_id !== 10'd204) begin failures++; $display("FAIL after_timeout_freq got=%0d exp=204", if_a.gen_freq_id); end
    endtask

    task automatic test_reset_mid();
        int busy_seen = 0;
        ready_en = 1'b0;
        request(5'd8);
        tick(); tick();
        request(5'd11);
        tick();
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_wait_busy got=%0b exp=1", busy_a); end
        rst = 1'b1;
        tick();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b exp=0", busy_a); end
        checks++; if (if_a.gen_new_f !== 2'b00) begin failures++; $display("FAIL mid_rst_strobe got=%b exp=00", if_a.gen_new_f); end
        checks++; if (if_a.gen_freq_id !== 10'd0) begin failures++; $display("FAIL mid_rst_freq got=%0d exp=0", if_a.gen_freq_id); end
        checks++; if (if_a.gen_index !== 11'd0) begin failures++; $display("FAIL mid_rst_index got=%0d exp=0", if_a.gen_index); end
        checks++; if (wave_a !== 10'd0 || player_a !== 10'd0) begin failures++; $display("FAIL mid_rst_profiles got=%0d/%0d exp=0/0", wave_a, player_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%0b exp=0", err_a); end
        rst = 1'b0; ready_en = 1'b1;
        log_q.delete();
        for (int i = 0; i < 10; i++) begin tick(); if (busy_a) busy_seen++; end
        checks++; if (busy_seen !== 0) begin failures++; $display("FAIL mid_rst_no_load got=%0d exp=0", busy_seen); end
        checks++; if (log_q.size() !== 0) begin failures++; $display("FAIL mid_rst_no_strobe got=%0d exp=0", log_q.size()); end
        checks++; if (wave_a !== 10'd400) begin failures++; $display("FAIL mid_rst_cur_wave got=%0d exp=400", wave_a); end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_swap();
        test_decay();
        test_blend();
        test_latency();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
